// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding request at a time, a registered
// instruction/PC+4 pair for decode, and branch redirects with stale-response
// discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        Branch_i,
  input  logic [31:0] BranchTarget_i,
  input  logic        Stall_i,
  output logic [31:0] Instr_o,
  output logic [5:0]  Op_o,
  output logic [31:0] PcPlus4_o,
  output logic        InstrValid_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state;
  logic [1:0]  stateNext;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic        discard;
  logic        discardNext;
  logic        loadInstr;
  logic [31:0] instrQ;
  logic [31:0] pcPlus4Q;

  // Next-state, next-PC and discard-flag decision; a branch overrides the PC
  // update of every state.
  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    discardNext = discard;
    loadInstr   = 1'b0;
    case (state)
      S_IDLE: begin
        stateNext = S_REQ;
      end
      S_REQ: begin
        // Without a grant the request stays pending; a branch only moves the
        // address, which is the one allowed change while pending.
        if (imem_gnt_i) begin
          stateNext = S_WAIT;
          if (Branch_i) begin
            discardNext = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (Branch_i || discard) begin
            // Stale response: drop it; PC already holds (or now takes) the target.
            discardNext = 1'b0;
            stateNext   = S_REQ;
          end else begin
            loadInstr = 1'b1;
            pcNext    = pc + 32'd4;
            stateNext = S_HOLD;
          end
        end else if (Branch_i) begin
          discardNext = 1'b1;
        end
      end
      S_HOLD: begin
        if (Branch_i || !Stall_i) begin
          stateNext = S_REQ;
        end
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase
    if (Branch_i) begin
      pcNext = BranchTarget_i;
    end
  end

  // FSM, PC and discard flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      discard <= 1'b0;
    end else begin
      state   <= stateNext;
      pc      <= pcNext;
      discard <= discardNext;
    end
  end

  // Instruction and PC+4 capture on an accepted response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instrQ   <= '0;
      pcPlus4Q <= '0;
    end else if (loadInstr) begin
      instrQ   <= imem_rdata_i;
      pcPlus4Q <= pc + 32'd4;
    end
  end

  assign imem_req_o   = (state == S_REQ);
  assign imem_addr_o  = pc;
  assign InstrValid_o = (state == S_HOLD);
  assign Instr_o      = instrQ;
  assign Op_o         = instrQ[31:26];
  assign PcPlus4_o    = pcPlus4Q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Port: clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 Port: imem_req_o  output  1  instruction-memory request valid.
REQ-005 Port: imem_addr_o  output  32  byte address of the request; always equals the internal PC.
REQ-006 Port: imem_gnt_i  input  1  memory accepts the request this cycle.
REQ-007 Port: imem_rvalid_i  input  1  read data valid.
REQ-008 Port: imem_rdata_i  input  32  instruction word.
REQ-009 Port: Branch_i  input  1  redirect request from the downstream stage (taken beq).
REQ-010 Port: BranchTarget_i  input  32  redirect address, sampled when Branch_i=1.
REQ-011 Port: Stall_i  input  1  decode stage cannot accept the held instruction.
REQ-012 Port: Instr_o  output  32  registered instruction word.
REQ-013 Port: Op_o  output  6  Instr_o[31:26], the opcode field fed to the main decoder.
REQ-014 Port: PcPlus4_o  output  32  address of Instr_o plus 4, registered with Instr_o.
REQ-015 Port: InstrValid_o  output  1  Instr_o/PcPlus4_o hold a valid, unflushed instruction.

Function
REQ-016 FSM states SHALL be S_IDLE, S_REQ, S_WAIT, S_HOLD; at most one memory request is outstanding.
REQ-017 S_IDLE: imem_req_o=0; go to S_REQ unconditionally on the next edge.
REQ-018 S_REQ: imem_req_o=1, imem_addr_o=PC; on imem_gnt_i=1 go to S_WAIT; otherwise stay, holding the address stable.
REQ-019 S_WAIT: imem_req_o=0; on imem_rvalid_i=1 with no pending discard, load Instr_o<=imem_rdata_i, PcPlus4_o<=PC+4, PC<=PC+4, and go to S_HOLD.
REQ-020 S_HOLD: InstrValid_o=1; if Stall_i=0, the instruction is consumed and the FSM goes to S_REQ, so InstrValid_o=0 on the next cycle; if Stall_i=1, all outputs hold.
REQ-021 InstrValid_o SHALL be 1 only in S_HOLD, with a minimum of 3 cycles per instruction given 1-cycle grant and response.
REQ-022 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 without error; the low 2 bits are not checked.
REQ-023 Branch_i has priority over every other event and sets PC<=BranchTarget_i.
REQ-024 Branch_i in S_REQ without grant: the FSM stays in S_REQ and the new address appears on imem_addr_o next cycle; this is the only case in which the address may change while the request is pending.
REQ-025 Branch_i in S_REQ with imem_gnt_i=1: set the discard flag and go to S_WAIT.
REQ-026 Branch_i in S_WAIT: set the discard flag; if imem_rvalid_i=1 in the same cycle, drop that response, clear discard, and go to S_REQ.
REQ-027 Response in S_WAIT with discard=1: drop the data, clear discard, go to S_REQ, and leave PC unchanged (it already holds the target).
REQ-028 Branch_i in S_HOLD: drop the held instruction regardless of Stall_i, InstrValid_o=0 next cycle, go to S_REQ.
REQ-029 Branch_i in S_IDLE: only the PC is updated; the transition to S_REQ is unaffected.
REQ-030 Stall_i SHALL be ignored outside S_HOLD.
REQ-031 imem_rvalid_i outside S_WAIT SHALL be ignored.

Reset
REQ-032 While rst_i=1: state=S_IDLE, PC=RESET_PC, discard=0, Instr_o=0, PcPlus4_o=0, InstrValid_o=0, imem_req_o=0, all asynchronously.
REQ-033 Reset asserted mid-transaction abandons any outstanding request; a late imem_rvalid_i after reset release SHALL be ignored because the FSM is in S_IDLE or S_REQ.

Verification
REQ-034 Reset release, memory grants immediately and responds 1 cycle later with 32'h8C01_0004 -> imem_req_o=1 with addr 0 in the 2nd cycle after release; InstrValid_o=1, Op_o=6'b100011, PcPlus4_o=4.
REQ-035 Stall_i=1 for 5 cycles in S_HOLD -> Instr_o, PcPlus4_o, and InstrValid_o=1 stable for all 5 cycles; the next request to addr 4 is issued the cycle after Stall_i falls.
REQ-036 Grant withheld 4 cycles -> imem_req_o=1 and addr constant for 4 cycles; then Branch_i=1 with target 32'h40 and no grant -> addr=32'h40 the next cycle.
REQ-037 Branch_i with target 32'h100 in S_WAIT, response 32'hDEAD_BEEF 2 cycles later -> word dropped, InstrValid_o stays 0, next request addr=32'h100.
REQ-038 RESET_PC=32'hFFFF_FFFC -> first PcPlus4_o=0, second fetch addr=0.
REQ-039 rst_i asserted in S_WAIT, rvalid arrives 1 cycle after release -> ignored; InstrValid_o=0; fetch restarts at RESET_PC.
